// File: rtl/shift_adder_pkg.sv
// Shared helpers for the shift_adder_array: portable clog2 and per-lane width/slice derivations.
// Optional build macro consumed elsewhere: SHIFT_ADDER_SIGNED_MSB_EN (MSB plane negative weight).
package shift_adder_pkg;

    function automatic int clog2_f(input int value);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    function automatic int win_f(input int kernal);
        return kernal * kernal;
    endfunction

    function automatic int cnt_w_f(input int kernal);
        return clog2_f(win_f(kernal) + 32'sd1);
    endfunction

    function automatic int out_w_f(input int kernal, input int in_bits);
        return cnt_w_f(kernal) + in_bits;
    endfunction

    function automatic int plane_w_f(input int in_bits);
        return clog2_f(in_bits) + 32'sd1;
    endfunction

    // Lane c of the packed output starts at this bit.
    function automatic int lane_lsb_f(input int lane, input int out_w);
        return lane * out_w;
    endfunction

    localparam int DEF_KERNAL  = 32'sd3;
    localparam int DEF_IN_BITS = 32'sd4;
    localparam int DEF_CH      = 32'sd2;
    localparam int DEF_WIN     = win_f(DEF_KERNAL);
    localparam int DEF_CNT_W   = cnt_w_f(DEF_KERNAL);
    localparam int DEF_OUT_W   = out_w_f(DEF_KERNAL, DEF_IN_BITS);

endpackage

// File: rtl/shift_adder_lane.sv
// One lane: popcounts the bits of a plane into psum and shift-adds completed planes into acc.
// With SHIFT_ADDER_SIGNED_MSB_EN defined the first (MSB) plane is subtracted instead of added.
module shift_adder_lane
    import shift_adder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             beat,
    input  logic             last_tap,
    input  logic             first_plane,
    input  logic             last_plane,
    input  logic             clear,
    output logic [OUT_W-1:0] result
);

    logic [CNT_W-1:0] psum_r;
    logic [OUT_W-1:0] acc_r;
    logic [CNT_W-1:0] sum_s;
    logic [OUT_W-1:0] acc_next_s;

    assign sum_s = psum_r + CNT_W'(in_bit);

    // Fold the completed plane sum into the accumulator; the first plane starts from zero.
    always_comb begin
        acc_next_s = {OUT_W{1'b0}};
        if (first_plane) begin
`ifdef SHIFT_ADDER_SIGNED_MSB_EN
            acc_next_s = {OUT_W{1'b0}} - OUT_W'(sum_s);
`else
            acc_next_s = OUT_W'(sum_s);
`endif
        end else begin
            acc_next_s = {acc_r[OUT_W-2:0], 1'b0} + OUT_W'(sum_s);
        end
    end

    assign result = acc_next_s;

    // psum/acc state; clear aborts the window and wins over a beat in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            psum_r <= {CNT_W{1'b0}};
            acc_r  <= {OUT_W{1'b0}};
        end else if (clear) begin
            psum_r <= {CNT_W{1'b0}};
            acc_r  <= {OUT_W{1'b0}};
        end else if (beat) begin
            if (last_tap) begin
                psum_r <= {CNT_W{1'b0}};
                acc_r  <= last_plane ? {OUT_W{1'b0}} : acc_next_s;
            end else begin
                psum_r <= sum_s;
                acc_r  <= acc_r;
            end
        end else begin
            psum_r <= psum_r;
            acc_r  <= acc_r;
        end
    end

endmodule

// File: rtl/shift_adder_array.sv
// CH-lane bit-serial popcount shift-adder with valid/ready on both sides and a registered output.
// Build option: SHIFT_ADDER_SIGNED_MSB_EN makes the MSB plane negative (two's complement out).
module shift_adder_array
    import shift_adder_pkg::*;
#(
    parameter  int KERNAL  = DEF_KERNAL,
    parameter  int IN_BITS = DEF_IN_BITS,
    parameter  int CH      = DEF_CH,
    localparam int WIN     = win_f(KERNAL),
    localparam int CNT_W   = cnt_w_f(KERNAL),
    localparam int OUT_W   = out_w_f(KERNAL, IN_BITS),
    localparam int PLANE_W = plane_w_f(IN_BITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH-1:0]         in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH*OUT_W-1:0]   out,
    output logic [PLANE_W-1:0]    plane_idx
);

    localparam logic [CNT_W-1:0]   TAP_LAST   = CNT_W'(WIN - 32'sd1);
    localparam logic [CNT_W-1:0]   TAP_ONE    = CNT_W'(32'sd1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(IN_BITS - 32'sd1);
    localparam logic [PLANE_W-1:0] PLANE_ONE  = PLANE_W'(32'sd1);

    logic [CNT_W-1:0]      tap_cnt_r;
    logic [PLANE_W-1:0]    plane_cnt_r;
    logic [CH*OUT_W-1:0]   out_r;
    logic                  out_valid_r;
    logic [CH*OUT_W-1:0]   result_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  last_tap_s;
    logic                  last_plane_s;
    logic                  first_plane_s;
    logic                  complete_s;

    assign in_ready_s    = !out_valid_r || out_ready;
    // A beat arriving together with flush is discarded, so it never counts as accepted.
    assign accept_s      = in_valid && in_ready_s && !flush;
    assign last_tap_s    = (tap_cnt_r == TAP_LAST);
    assign last_plane_s  = (plane_cnt_r == PLANE_LAST);
    assign first_plane_s = (plane_cnt_r == {PLANE_W{1'b0}});
    assign complete_s    = accept_s && last_tap_s && last_plane_s;

    // Shared tap/plane counters; they wrap exactly at WIN-1 and IN_BITS-1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tap_cnt_r   <= {CNT_W{1'b0}};
            plane_cnt_r <= {PLANE_W{1'b0}};
        end else if (flush) begin
            tap_cnt_r   <= {CNT_W{1'b0}};
            plane_cnt_r <= {PLANE_W{1'b0}};
        end else if (accept_s) begin
            if (last_tap_s) begin
                tap_cnt_r   <= {CNT_W{1'b0}};
                plane_cnt_r <= last_plane_s ? {PLANE_W{1'b0}} : (plane_cnt_r + PLANE_ONE);
            end else begin
                tap_cnt_r   <= tap_cnt_r + TAP_ONE;
                plane_cnt_r <= plane_cnt_r;
            end
        end else begin
            tap_cnt_r   <= tap_cnt_r;
            plane_cnt_r <= plane_cnt_r;
        end
    end

    // Output register: a completing window reloads even while the old result is being consumed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r       <= {(CH*OUT_W){1'b0}};
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_r       <= result_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_r       <= out_r;
            out_valid_r <= 1'b0;
        end else begin
            out_r       <= out_r;
            out_valid_r <= out_valid_r;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        shift_adder_lane #(
            .CNT_W (CNT_W),
            .OUT_W (OUT_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .in_bit      (in[c]),
            .beat        (accept_s),
            .last_tap    (last_tap_s),
            .first_plane (first_plane_s),
            .last_plane  (last_plane_s),
            .clear       (flush),
            .result      (result_s[lane_lsb_f(c, OUT_W) +: OUT_W])
        );
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out       = out_r;
    assign plane_idx = plane_cnt_r;

endmodule
